// File: rtl/spi_master.sv
// Mode-0 SPI master: one BIT_WIDTH-bit word per transaction, MSB first, single chip select.
// SCK comes from a clock-enable divider; MISO is synchronized before it is sampled.
module spi_master #(
    parameter int BIT_WIDTH   = 8,
    parameter int HALF_PERIOD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] tx_data,
    input  logic                 miso,
    output logic                 sck,
    output logic                 ssel,
    output logic                 mosi,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] rx_data
);

    localparam int DIV_W = $clog2(HALF_PERIOD);
    localparam int CNT_W = $clog2(BIT_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t               state, state_nx;
    logic [DIV_W-1:0]     div_cnt, div_nx;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nx;
    logic [BIT_WIDTH-1:0] tx_sr, tx_sr_nx;
    logic [BIT_WIDTH-1:0] rx_sr, rx_sr_nx;
    logic [BIT_WIDTH-1:0] rx_data_nx;
    logic                 sck_nx, ssel_nx, mosi_nx, busy_nx, done_nx;
    logic                 miso_sync_p0, miso_sync_p1;
    logic                 tick;

    // MISO synchronizer stages
    always_ff @(posedge clk) begin
        miso_sync_p0 <= miso;
        miso_sync_p1 <= miso_sync_p0;
    end

    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        tx_sr_nx   = tx_sr;
        rx_sr_nx   = rx_sr;
        rx_data_nx = rx_data;
        sck_nx     = sck;
        ssel_nx    = ssel;
        mosi_nx    = mosi;
        busy_nx    = busy;
        done_nx    = 1'b0;
        unique case (state)
            S_IDLE: begin
                sck_nx     = 1'b0;
                ssel_nx    = 1'b1;
                mosi_nx    = 1'b0;
                bit_cnt_nx = '0;
                if (start) begin
                    tx_sr_nx = tx_data;
                    ssel_nx  = 1'b0;
                    mosi_nx  = tx_data[BIT_WIDTH-1];
                    busy_nx  = 1'b1;
                    state_nx = S_SETUP;
                end
            end
            S_SETUP, S_LOW: begin
                if (tick) begin
                    sck_nx   = 1'b1;
                    state_nx = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    rx_sr_nx   = {rx_sr[BIT_WIDTH-2:0], miso_sync_p1};
                    sck_nx     = 1'b0;
                    bit_cnt_nx = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = S_HOLD;
                    end else begin
                        tx_sr_nx = {tx_sr[BIT_WIDTH-2:0], 1'b0};
                        mosi_nx  = tx_sr[BIT_WIDTH-2];
                        state_nx = S_LOW;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    ssel_nx    = 1'b1;
                    mosi_nx    = 1'b0;
                    rx_data_nx = rx_sr;
                    done_nx    = 1'b1;
                    state_nx   = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    busy_nx  = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Divider restarts whenever a new state is entered and rests in IDLE
        if ((state == S_IDLE) || (state_nx != state)) begin
            div_nx = '0;
        end else begin
            div_nx = div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            ssel    <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            bit_cnt <= bit_cnt_nx;
            sck     <= sck_nx;
            ssel    <= ssel_nx;
            mosi    <= mosi_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            rx_data <= rx_data_nx;
        end
    end

    // Shift registers carry data only and are always reloaded before use
    always_ff @(posedge clk) begin
        tx_sr <= tx_sr_nx;
        rx_sr <= rx_sr_nx;
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: an N=8/H=8 instance (loopback or behavioural slave) and an
// N=16/H=4 instance (loopback), with per-cycle protocol monitoring.
module tb_spi_master;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [7:0]  tx_data_a = '0, rx_data_a;
    logic [15:0] tx_data_b = '0, rx_data_b;
    logic        miso_a, miso_b;
    logic        sck_a, ssel_a, mosi_a, busy_a, done_a;
    logic        sck_b, ssel_b, mosi_b, busy_b, done_b;

    logic        loop_a = 1'b1;
    logic [7:0]  slave_tx = '0;
    logic [7:0]  slave_rx = '0;
    logic        slave_miso = 1'b0;
    int          s_idx = 0;

    assign miso_a = loop_a ? mosi_a : slave_miso;
    assign miso_b = mosi_b;

    spi_master #(.BIT_WIDTH(8), .HALF_PERIOD(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .tx_data(tx_data_a), .miso(miso_a),
        .sck(sck_a), .ssel(ssel_a), .mosi(mosi_a), .busy(busy_a), .done(done_a),
        .rx_data(rx_data_a)
    );

    spi_master #(.BIT_WIDTH(16), .HALF_PERIOD(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tx_data(tx_data_b), .miso(miso_b),
        .sck(sck_b), .ssel(ssel_b), .mosi(mosi_b), .busy(busy_b), .done(done_b),
        .rx_data(rx_data_b)
    );

    // Mode-0 slave: MSB out at select, next bit after each SCK fall, capture on SCK rise
    always @(negedge ssel_a) begin
        s_idx      <= 7;
        slave_miso <= slave_tx[7];
    end
    always @(negedge sck_a) begin
        if (!ssel_a && s_idx > 0) begin
            s_idx      <= s_idx - 1;
            slave_miso <= slave_tx[s_idx-1];
        end
    end
    always @(posedge sck_a) begin
        if (!ssel_a) slave_rx <= {slave_rx[6:0], mosi_a};
    end

    logic [1:0]  sck_v, ssel_v, mosi_v, busy_v, done_v;
    logic [15:0] rx_v [2];
    assign sck_v  = {sck_b, sck_a};
    assign ssel_v = {ssel_b, ssel_a};
    assign mosi_v = {mosi_b, mosi_a};
    assign busy_v = {busy_b, busy_a};
    assign done_v = {done_b, done_a};
    assign rx_v[0] = {8'h00, rx_data_a};
    assign rx_v[1] = rx_data_b;

    int rises [2] = '{0, 0};
    int ssel_low [2] = '{0, 0};
    int busy_cyc [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int viol [2] = '{0, 0};
    logic [1:0] sck_q = '0, mosi_q = '0, done_q = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sck_v[i] && !sck_q[i]) rises[i] <= rises[i] + 1;
            if (!ssel_v[i]) ssel_low[i] <= ssel_low[i] + 1;
            if (busy_v[i]) busy_cyc[i] <= busy_cyc[i] + 1;
            if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
            if ((sck_v[i] && sck_q[i] && (mosi_v[i] !== mosi_q[i])) ||
                (ssel_v[i] && sck_v[i]) || (done_v[i] && done_q[i]))
                viol[i] <= viol[i] + 1;
        end
        sck_q  <= sck_v;
        mosi_q <= mosi_v;
        done_q <= done_v;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction; entered and left at a negedge with the selected DUT idle
    task automatic xfer(input int d, input logic [15:0] tx, input logic loop,
                        input logic [15:0] swd, input logic extra);
        int n = (d == 1) ? 16 : 8;
        int h = (d == 1) ? 4 : 8;
        logic [15:0] mask = (d == 1) ? 16'hFFFF : 16'h00FF;
        logic [15:0] exp_rx;
        int r0, s0, b0, dn0, v0;
        bit got = 0;
        exp_rx = (loop ? tx : swd) & mask;
        r0 = rises[d]; s0 = ssel_low[d]; b0 = busy_cyc[d]; dn0 = done_cnt[d]; v0 = viol[d];
        if (d == 0) begin
            loop_a = loop;
            slave_tx = swd[7:0];
            tx_data_a = tx[7:0];
            start_a = 1'b1;
        end else begin
            tx_data_b = tx;
            start_b = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check("ssel_fall", 32'(ssel_v[d]), 32'd0);
        tx_data_a = 8'($urandom);
        tx_data_b = 16'($urandom);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (extra && c == n * h) begin
                if (d == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            if (done_v[d]) begin
                got = 1;
                check("rx_at_done", 32'(rx_v[d]), 32'(exp_rx));
                check("ssel_at_done", 32'(ssel_v[d]), 32'd1);
                if (extra) begin
                    if (d == 0) start_a = 1'b1; else start_b = 1'b1;
                end
            end
            if (!busy_v[d]) break;
        end
        check("done_seen", 32'(got), 32'd1);
        check("busy_end", 32'(busy_v[d]), 32'd0);
        check("rx_held", 32'(rx_v[d]), 32'(exp_rx));
        check("sck_pulses", 32'(rises[d] - r0), 32'(n));
        check("ssel_low_cycles", 32'(ssel_low[d] - s0), 32'((2 * n + 1) * h));
        check("busy_cycles", 32'(busy_cyc[d] - b0), 32'((2 * n + 2) * h));
        check("done_count", 32'(done_cnt[d] - dn0), 32'd1);
        check("protocol", 32'(viol[d] - v0), 32'd0);
        if (d == 0 && !loop) check("slave_rx", 32'(slave_rx), 32'(tx[7:0]));
    endtask

    initial begin
        int r0, dn0;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(sck_v), 32'd0);
        check("rst_ssel", 32'(ssel_v), 32'd3);
        check("rst_mosi", 32'(mosi_v), 32'd0);
        check("rst_busy", 32'(busy_v), 32'd0);
        check("rst_done", 32'(done_v), 32'd0);
        check("rst_rx_a", 32'(rx_v[0]), 32'd0);
        check("rst_rx_b", 32'(rx_v[1]), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset after the third SCK rise: no report, outputs back to idle values
        r0 = rises[0];
        dn0 = done_cnt[0];
        loop_a = 1'b1;
        tx_data_a = 8'h96;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seen = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (rises[0] - r0 >= 3) begin
                seen = 1;
                break;
            end
        end
        check("third_rise_seen", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ssel", 32'(ssel_a), 32'd1);
        check("midrst_sck", 32'(sck_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_mosi", 32'(mosi_a), 32'd0);
        repeat (200) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt[0] - dn0), 32'd0);
        check("midrst_rx", 32'(rx_data_a), 32'd0);
        check("midrst_idle", 32'(ssel_a), 32'd1);

        xfer(0, 16'h005A, 1'b1, 16'h0000, 1'b0);
        xfer(0, 16'h00A5, 1'b1, 16'h0000, 1'b1);
        xfer(0, 16'h00C3, 1'b0, 16'h003C, 1'b0);
        for (int k = 0; k < 6; k++) begin
            xfer(0, 16'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
        end

        xfer(1, 16'hBEEF, 1'b1, 16'h0000, 1'b0);
        xfer(1, 16'h0000, 1'b1, 16'h0000, 1'b0);
        xfer(1, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            xfer(1, 16'($urandom), 1'b1, 16'h0000, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
